// File: rtl/wb_exc_commit.sv
// wb_exc_commit: writeback-stage exception / ERET / commit controller.
// Decides each retiring instruction's fate, drives the CP0 exception and ERET
// inputs combinationally, and issues a registered multi-cycle flush with a
// fetch redirect target. Tracks branch-delay-slot state across retirements.
// Optional feature: define WB_EXC_REFILL_VEC_EN to route TLB refill misses
// (TLBL/TLBS, EXL clear) to the dedicated refill vector.

package wb_exc_pkg;

  typedef struct packed {
    logic        ex;
    logic        bd;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [4:0]  EXC_TLBL    = 5'd2;
  localparam logic [4:0]  EXC_TLBS    = 5'd3;
  localparam logic [31:0] VEC_GENERAL = 32'hBFC0_0380;
  localparam logic [31:0] VEC_REFILL  = 32'hBFC0_0200;

endpackage

module wb_exc_commit
  import wb_exc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [31:0] ws_pc,
  input  exception_t  ws_ex,
  input  logic        ws_tlb_refill,
  input  logic        ws_is_branch,
  input  logic        ws_eret,
  input  logic [5:0]  c0_hw,
  input  logic [1:0]  c0_sw,
  input  logic        c0_exl,
  input  logic [31:0] epc,
  output exception_t  exception,
  output logic        eret_flush,
  output logic [31:0] wb_pc,
  output logic        commit_o,
  output logic        flush_o,
  output logic [31:0] flush_pc
);

  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bd_q, bd_d;
  logic [31:0]        flush_pc_q, flush_pc_d;

  logic ret;
  logic int_req;
  logic take_int;
  logic take_exc;
  logic take_eret;
  logic take_commit;
  logic refill_hit;
  logic unused_inputs;

  // Classify the retiring instruction: interrupt > upstream exception > ERET > normal.
  always_comb begin
    ret         = ws_valid && (state_q == S_IDLE);
    int_req     = |{c0_hw, c0_sw};
    take_int    = ret && int_req;
    take_exc    = ret && !int_req && ws_ex.ex;
    take_eret   = ret && !int_req && !ws_ex.ex && ws_eret;
    take_commit = ret && !int_req && !ws_ex.ex && !ws_eret;
  end

`ifdef WB_EXC_REFILL_VEC_EN
  // Refill vector only for a first-level TLB miss on load/store.
  always_comb begin
    refill_hit = ws_tlb_refill && !c0_exl &&
                 ((ws_ex.exccode == EXC_TLBL) || (ws_ex.exccode == EXC_TLBS));
  end
`else
  // Without the refill vector every exception goes to the general vector.
  always_comb begin
    refill_hit = 1'b0;
  end
`endif

  // The upstream bd bit is replaced by the locally tracked delay-slot flag;
  // refill inputs are only consumed when the refill vector is built in.
  assign unused_inputs = ^{ws_tlb_refill, c0_exl, ws_ex.bd};

  // CP0-facing outputs, valid only in the retire cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    exception  = '0;
    eret_flush = take_eret;
    commit_o   = take_commit;
    wb_pc      = ret ? ws_pc : 32'h0;
    if (take_int) begin
      exception.ex      = 1'b1;
      exception.exccode = EXC_INT;
      exception.bd      = bd_q;
    end else if (take_exc) begin
      exception    = ws_ex;
      exception.bd = bd_q;
    end
  end

  // Next-state: enter FLUSH on exception/ERET, count down, return to IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bd_d       = bd_q;
    flush_pc_d = flush_pc_q;
    case (state_q)
      S_IDLE: begin
        if (take_int || take_exc || take_eret) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_LOAD;
          bd_d    = 1'b0;
          if (take_eret)
            flush_pc_d = epc;
          else if (take_exc && refill_hit)
            flush_pc_d = VEC_REFILL;
          else
            flush_pc_d = VEC_GENERAL;
        end else if (take_commit) begin
          bd_d = ws_is_branch;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0)
          state_d = S_IDLE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bd_q       <= 1'b0;
      flush_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bd_q       <= bd_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign ws_ready = (state_q == S_IDLE);
  assign flush_o  = (state_q == S_FLUSH);
  assign flush_pc = flush_pc_q;

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the controller.
module tb_wb_exc_commit;
  import wb_exc_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid;
  logic        ws_ready;
  logic [31:0] ws_pc;
  exception_t  ws_ex;
  logic        ws_tlb_refill;
  logic        ws_is_branch;
  logic        ws_eret;
  logic [5:0]  c0_hw;
  logic [1:0]  c0_sw;
  logic        c0_exl;
  logic [31:0] epc;
  exception_t  exception;
  logic        eret_flush;
  logic [31:0] wb_pc;
  logic        commit_o;
  logic        flush_o;
  logic [31:0] flush_pc;

  int n_pass  = 0;
  int n_total = 0;

  wb_exc_commit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc), .ws_ex(ws_ex),
    .ws_tlb_refill(ws_tlb_refill), .ws_is_branch(ws_is_branch), .ws_eret(ws_eret),
    .c0_hw(c0_hw), .c0_sw(c0_sw), .c0_exl(c0_exl), .epc(epc),
    .exception(exception), .eret_flush(eret_flush), .wb_pc(wb_pc),
    .commit_o(commit_o), .flush_o(flush_o), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ws_valid = 0; ws_pc = 0; ws_ex = '0; ws_tlb_refill = 0; ws_is_branch = 0;
    ws_eret = 0; c0_hw = 0; c0_sw = 0; c0_exl = 0; epc = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    repeat (2) next_cycle();
    @(negedge clk);
    n_total++; if (flush_o !== 1'b0) $display("FAIL reset_flush_o got %0b want 0", flush_o); else n_pass++;
    n_total++; if (ws_ready !== 1'b1) $display("FAIL reset_ws_ready got %0b want 1", ws_ready); else n_pass++;
    n_total++; if (flush_pc !== 32'h0) $display("FAIL reset_flush_pc got %h want 0", flush_pc); else n_pass++;
    resetn = 1;
    next_cycle();
    @(negedge clk);
    n_total++;
    if ({exception, eret_flush, commit_o, wb_pc} !== '0)
      $display("FAIL idle_comb_outputs got %h want 0", {exception, eret_flush, commit_o, wb_pc});
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_branch_delay_slot();
    ws_valid = 1; ws_pc = 32'hBFC0_0010; ws_is_branch = 1;
    @(negedge clk);
    n_total++;
    if ({commit_o, exception.ex, wb_pc} !== {1'b1, 1'b0, 32'hBFC0_0010})
      $display("FAIL branch_commit got commit=%0b ex=%0b pc=%h want 1 0 bfc00010", commit_o, exception.ex, wb_pc);
    else n_pass++;
    next_cycle();
    ws_pc = 32'hBFC0_0014; ws_is_branch = 0;
    ws_ex = '{ex: 1'b1, bd: 1'b0, exccode: 5'd4, badvaddr: 32'h0000_0123};
    @(negedge clk);
    n_total++;
    if ({exception, commit_o} !== {1'b1, 1'b1, 5'd4, 32'h0000_0123, 1'b0})
      $display("FAIL delay_slot_exc got %h commit=%0b want ex=1 bd=1 code=4", exception, commit_o);
    else n_pass++;
    next_cycle();
    clear_inputs();
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      n_total++;
      if ({flush_o, ws_ready, flush_pc} !== {1'b1, 1'b0, 32'hBFC0_0380})
        $display("FAIL dslot_flush_c%0d got flush=%0b ready=%0b pc=%h want 1 0 bfc00380", k+1, flush_o, ws_ready, flush_pc);
      else n_pass++;
      next_cycle();
    end
    @(negedge clk);
    n_total++;
    if ({flush_o, ws_ready} !== 2'b01)
      $display("FAIL dslot_flush_end got flush=%0b ready=%0b want 0 1", flush_o, ws_ready);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_interrupt();
    ws_valid = 1; ws_pc = 32'h8000_0040; ws_eret = 1; c0_hw = 6'b000001; epc = 32'h8000_5555;
    @(negedge clk);
    n_total++;
    if ({exception.ex, exception.exccode, eret_flush, commit_o} !== {1'b1, 5'd0, 1'b0, 1'b0})
      $display("FAIL int_over_eret got ex=%0b code=%0d eret=%0b commit=%0b want 1 0 0 0",
               exception.ex, exception.exccode, eret_flush, commit_o);
    else n_pass++;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_total++;
    if ({flush_o, flush_pc} !== {1'b1, 32'hBFC0_0380})
      $display("FAIL int_flush got flush=%0b pc=%h want 1 bfc00380", flush_o, flush_pc);
    else n_pass++;
    repeat (FC) next_cycle();
  endtask

  task automatic test_eret();
    ws_valid = 1; ws_pc = 32'h8000_0100; ws_eret = 1; epc = 32'h8000_1234;
    @(negedge clk);
    n_total++;
    if ({eret_flush, commit_o, exception.ex} !== 3'b100)
      $display("FAIL eret_c got eret=%0b commit=%0b ex=%0b want 1 0 0", eret_flush, commit_o, exception.ex);
    else n_pass++;
    next_cycle();
    epc = 32'h0;  // target must have been sampled in the retire cycle
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      n_total++;
      if ({flush_o, ws_ready, flush_pc, eret_flush} !== {1'b1, 1'b0, 32'h8000_1234, 1'b0})
        $display("FAIL eret_flush_c%0d got flush=%0b ready=%0b pc=%h eret=%0b want 1 0 80001234 0",
                 k+1, flush_o, ws_ready, flush_pc, eret_flush);
      else n_pass++;
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    n_total++; if (ws_ready !== 1'b1) $display("FAIL eret_ready_after got %0b want 1", ws_ready); else n_pass++;
  endtask

  task automatic test_refill();
    logic [31:0] want;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      ws_valid = 1; ws_pc = 32'h0040_0000 + 32'(i * 4); ws_tlb_refill = 1;
      ws_ex = '{ex: 1'b1, bd: 1'b0, exccode: (i == 2) ? 5'd4 : 5'd2, badvaddr: 32'h1234_5000};
      c0_exl = (i == 1);
`ifdef WB_EXC_REFILL_VEC_EN
      want = (i == 0) ? 32'hBFC0_0200 : 32'hBFC0_0380;
`else
      want = 32'hBFC0_0380;
`endif
      next_cycle();
      clear_inputs();
      @(negedge clk);
      n_total++;
      if ({flush_o, flush_pc} !== {1'b1, want})
        $display("FAIL refill_case%0d got flush=%0b pc=%h want 1 %h", i, flush_o, flush_pc, want);
      else n_pass++;
      repeat (FC) next_cycle();
    end
  endtask

  task automatic test_reset_in_flush();
    // First prove bd is set, then abort a flush and check bd is gone.
    ws_valid = 1; ws_pc = 32'h8000_0200; ws_is_branch = 1;
    next_cycle();
    clear_inputs();
    ws_valid = 1; ws_pc = 32'h8000_0204; ws_eret = 1; epc = 32'h8000_0300;
    next_cycle();                 // C+1: in FLUSH
    clear_inputs();
    resetn = 0;
    @(negedge clk);
    n_total++; if (flush_o !== 1'b1) $display("FAIL rif_flush_c1 got %0b want 1", flush_o); else n_pass++;
    next_cycle();                 // C+2
    @(negedge clk);
    n_total++;
    if ({flush_o, ws_ready} !== 2'b01)
      $display("FAIL rif_abort got flush=%0b ready=%0b want 0 1", flush_o, ws_ready);
    else n_pass++;
    resetn = 1;
    next_cycle();
    // Branch retire sets bd, then reset clears it.
    ws_valid = 1; ws_pc = 32'h8000_0400; ws_is_branch = 1;
    next_cycle();
    clear_inputs();
    resetn = 0;
    next_cycle();
    resetn = 1;
    ws_valid = 1; ws_pc = 32'h8000_0404;
    ws_ex = '{ex: 1'b1, bd: 1'b1, exccode: 5'd10, badvaddr: 32'h0};
    @(negedge clk);
    n_total++;
    if ({exception.ex, exception.bd} !== 2'b10)
      $display("FAIL rif_bd_cleared got ex=%0b bd=%0b want 1 0", exception.ex, exception.bd);
    else n_pass++;
    next_cycle();
    clear_inputs();
    repeat (FC) next_cycle();
  endtask

  task automatic test_random(input int cycles);
    int          busy;
    logic        m_bd;
    logic [31:0] m_tgt;
    exception_t  e_exc;
    logic        ret, intr, refill;
    logic [4:0]  codes [5];
    codes = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd10};
    // reset the model and the DUT together
    resetn = 0; clear_inputs(); next_cycle(); resetn = 1;
    busy = 0; m_bd = 0; m_tgt = 32'h0;
    for (int n = 0; n < cycles; n++) begin
      ws_valid      = ($urandom_range(99) < 70);
      ws_pc         = $urandom & 32'hFFFF_FFFC;
      ws_ex.ex      = ($urandom_range(99) < 20);
      ws_ex.bd      = 1'($urandom);
      ws_ex.exccode = codes[$urandom_range(4)];
      ws_ex.badvaddr = $urandom;
      ws_tlb_refill = 1'($urandom);
      ws_is_branch  = ($urandom_range(99) < 30);
      ws_eret       = ($urandom_range(99) < 15);
      c0_hw         = ($urandom_range(99) < 12) ? 6'(1 << $urandom_range(5)) : 6'h0;
      c0_sw         = ($urandom_range(99) < 4) ? 2'b10 : 2'b00;
      c0_exl        = 1'($urandom);
      epc           = $urandom;

      ret  = ws_valid && (busy == 0);
      intr = (c0_hw != 0) || (c0_sw != 0);
`ifdef WB_EXC_REFILL_VEC_EN
      refill = ws_tlb_refill && !c0_exl && (ws_ex.exccode == 5'd2 || ws_ex.exccode == 5'd3);
`else
      refill = 1'b0;
`endif
      e_exc = '0;
      if (ret && intr) begin
        e_exc.ex = 1'b1; e_exc.bd = m_bd;
      end else if (ret && ws_ex.ex) begin
        e_exc = ws_ex; e_exc.bd = m_bd;
      end

      @(negedge clk);
      n_total++;
      if ({exception, eret_flush, commit_o, wb_pc} !==
          {e_exc, ret && !intr && !ws_ex.ex && ws_eret, ret && !intr && !ws_ex.ex && !ws_eret,
           ret ? ws_pc : 32'h0})
        $display("FAIL rand_comb_%0d got exc=%h eret=%0b commit=%0b pc=%h want exc=%h",
                 n, exception, eret_flush, commit_o, wb_pc, e_exc);
      else n_pass++;
      n_total++;
      if ({flush_o, ws_ready} !== {busy > 0, busy == 0} || (busy > 0 && flush_pc !== m_tgt))
        $display("FAIL rand_flush_%0d got flush=%0b ready=%0b pc=%h want flush=%0b pc=%h",
                 n, flush_o, ws_ready, flush_pc, busy > 0, m_tgt);
      else n_pass++;

      // advance the model to the next cycle
      if (ret) begin
        if (intr || ws_ex.ex || ws_eret) begin
          busy  = FC;
          m_bd  = 1'b0;
          m_tgt = (!intr && !ws_ex.ex) ? epc : (!intr && refill) ? 32'hBFC0_0200 : 32'hBFC0_0380;
        end else begin
          m_bd = ws_is_branch;
        end
      end else if (busy > 0) begin
        busy--;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_branch_delay_slot();
    test_interrupt();
    test_eret();
    test_refill();
    test_reset_in_flush();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_exc_commit.md
# wb_exc_commit

Writeback-stage exception/commit controller sitting directly upstream of the CP0 register file. It takes the instruction leaving WB plus the CP0 interrupt lines and decides whether it retires normally, takes an exception (interrupt has priority) or executes ERET. It drives the CP0 exception/ERET inputs and `wb_pc`, and produces a registered, multi-cycle pipeline flush with the redirect target for fetch. It also tracks branch-delay-slot state across retirements.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: cycles `flush_o` stays high per redirect (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `ws_valid`  in  1  WB holds an instruction.
- `ws_ready`  out  1  WB may retire this cycle.
- `ws_pc`  in  32  PC of WB instruction.
- `ws_ex`  in  exception_t  exception raised upstream (`ex`, `exccode`, `badvaddr`; `bd` ignored).
- `ws_tlb_refill`  in  1  `ws_ex` is a TLB miss (not invalid/modified).
- `ws_is_branch`  in  1  instruction is a branch/jump (next instruction is its delay slot).
- `ws_eret`  in  1  instruction is ERET.
- `c0_hw`  in  6  masked hardware interrupt lines from CP0.
- `c0_sw`  in  2  masked software interrupt lines from CP0.
- `c0_exl`  in  1  CP0 Status.EXL.
- `epc`  in  32  CP0 EPC.
- `exception`  out  exception_t  exception to CP0.
- `eret_flush`  out  1  ERET to CP0.
- `wb_pc`  out  32  PC to CP0.
- `commit_o`  out  1  instruction retires normally (gates regfile/HI-LO write).
- `flush_o`  out  1  flush all stages.
- `flush_pc`  out  32  redirect target, valid while `flush_o`.

## Operation
- States: IDLE, FLUSH. Retire event `ret = ws_valid && state==IDLE`; `ws_ready = (state==IDLE)`.
- `int_req = |{c0_hw, c0_sw}` (already masked by IE/EXL/IM in CP0).
- Priority on `ret`: interrupt > `ws_ex.ex` > `ws_eret` > normal.
  - Interrupt: `exception.ex=1`, `exccode=0` (INT), instruction does not retire.
  - Upstream exception: `exception` = `ws_ex` with its exccode/badvaddr.
  - ERET: `eret_flush=1`.
  - Normal: `commit_o=1`.
- `exception.bd = bd_r`; `wb_pc = ws_pc`. CP0 applies the delay-slot EPC correction.
- `bd_r` is set on a normal retire with `ws_is_branch=1`, cleared on any other retire and on entry to FLUSH.
- Redirect targets:
  - Exception: `0xBFC00200` if refill vector applies (see Configuration), else `0xBFC00380`.
  - ERET: `epc` sampled in the retire cycle.
- Any exception or ERET retire moves the FSM IDLE→FLUSH, latches the target and loads the counter with `FLUSH_CYCLES-1`.
- In FLUSH: `flush_o=1`; counter decrements; at 0 → IDLE. `ws_valid` is ignored in FLUSH (no outputs asserted).

## Timing
- `exception`, `eret_flush`, `commit_o`, `wb_pc` are combinational in retire cycle C, so CP0 updates at end of C.
- `flush_o`/`flush_pc` are registered: high in C+1 … C+FLUSH_CYCLES. The next retire is possible at C+FLUSH_CYCLES+1.
- Reset values: state IDLE, `bd_r=0`, counter 0, `flush_o=0`, `flush_pc=0`. Combinational outputs are 0 while `ws_valid=0`.
- `resetn` low during FLUSH aborts it immediately; `flush_o=0` in the next cycle.
- An interrupt rising during FLUSH or while `ws_valid=0` is not taken; it is taken on the first retire after, if still requested.
- `int_req` with `ws_eret`: interrupt wins, no `eret_flush`.
- `ws_ex.ex` with `ws_is_branch`: exception; `bd_r` cleared.
- Exception with `c0_exl=1`: vector `0xBFC00380` regardless of `ws_tlb_refill`.

## Configuration
- `WB_EXC_REFILL_VEC_EN` defined: exceptions with `ws_tlb_refill=1`, `c0_exl=0` and exccode TLBL(2)/TLBS(3) vector to `0xBFC00200`.
- Undefined: `ws_tlb_refill` is unused; all exceptions vector to `0xBFC00380`.

## Test plan
- Normal branch then delay slot: pc `0xBFC00010` branch, then `0xBFC00014` with `ws_ex.ex=1`, exccode 4 → `exception.bd=1`, `flush_o` high 2 cycles, `flush_pc=0xBFC00380`.
- Interrupt: `c0_hw=6'b000001` with `ws_valid=1`, `ws_eret=1` → `exception.exccode=0`, `eret_flush=0`, `commit_o=0`.
- ERET: `epc=0x80001234`, `ws_eret=1` → `eret_flush=1` in C, `flush_pc=0x80001234` in C+1..C+2, `ws_ready=0` in C+1..C+2.
- Refill: exccode 2, `ws_tlb_refill=1`, `c0_exl=0` → `flush_pc=0xBFC00200` with macro, `0xBFC00380` without; with `c0_exl=1` → `0xBFC00380`.
- Reset in FLUSH: `resetn=0` in C+1 → `flush_o=0` and `ws_ready=1` from C+2; `bd_r=0` (next exception reports `bd=0`).
